// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared op encoding, FSM states and divider latency for div_ctrl
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4
  } op_e;

  typedef enum logic {
    DC_IDLE = 1'b0,
    DC_BUSY = 1'b1
  } state_e;

  // Cycles from the divider's first counting cycle (count 0) to its complete pulse
  localparam int DIV_LATENCY = 33;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/div_ctrl_hilo_regs.sv
// rtl/div_ctrl_hilo_regs.sv - architectural HI/LO registers with independent write enables
module hilo_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_we,
  input  logic [31:0] hi_d,
  input  logic        lo_we,
  input  logic [31:0] lo_d,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // HI holds the remainder / MTHI value
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
    end else if (hi_we) begin
      hi <= hi_d;
    end
  end

  // LO holds the quotient / MTLO value
  always_ff @(posedge clk) begin
    if (reset) begin
      lo <= '0;
    end else if (lo_we) begin
      lo <= lo_d;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - divide sequencing and HI/LO commit stage; optional DIV_ZERO_SKIP_EN skips divide-by-zero
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        ex_flush,
  output logic        stall,
  output logic        busy,
  output logic        div_req,
  output logic        div_sgn,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state;
  state_e      state_next;
  logic        accept;
  logic        zero_skip;
  logic        div_start;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  assign accept = ex_valid & ~ex_flush;

`ifdef DIV_ZERO_SKIP_EN
  assign zero_skip = (ex_rt == 32'd0);
`else
  assign zero_skip = 1'b0;
`endif

  // State register; reset always lands in IDLE so div_req is low the next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latches: written only on the request cycle, held steady while the divider runs
  always_ff @(posedge clk) begin
    if (reset) begin
      div_x   <= '0;
      div_y   <= '0;
      div_sgn <= 1'b0;
    end else if (div_start) begin
      div_x   <= ex_rs;
      div_y   <= ex_rt;
      div_sgn <= (ex_op == OP_DIV);
    end
  end

  // Next-state, divider handshake, stall and HI/LO write decode
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    stall      = 1'b0;
    busy       = 1'b0;
    div_req    = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = ex_rs;
    lo_d       = ex_rs;
    case (state)
      DC_IDLE: begin
        if (accept) begin
          if (is_div_op(ex_op)) begin
            if (!zero_skip) begin
              div_start  = 1'b1;
              stall      = 1'b1;
              state_next = DC_BUSY;
            end
          end else if (ex_op == OP_MTHI) begin
            hi_we = 1'b1;
          end else if (ex_op == OP_MTLO) begin
            lo_we = 1'b1;
          end
        end
      end
      DC_BUSY: begin
        div_req = 1'b1;
        busy    = 1'b1;
        stall   = ~div_done;
        // A flush beats a same-cycle completion: the killed divide must not commit
        if (ex_flush) begin
          state_next = DC_IDLE;
        end else if (div_done) begin
          hi_we      = 1'b1;
          lo_we      = 1'b1;
          hi_d       = div_r;
          lo_d       = div_s;
          state_next = DC_IDLE;
        end
      end
      default: begin
        state_next = DC_IDLE;
      end
    endcase
    if (reset) begin
      stall = 1'b0;
    end
  end

  hilo_regs u_hilo (
    .clk   (clk),
    .reset (reset),
    .hi_we (hi_we),
    .hi_d  (hi_d),
    .lo_we (lo_we),
    .lo_d  (lo_d),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - bench for div_ctrl with a behavioural divider and HI/LO reference model
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        ex_flush;
  logic        stall;
  logic        busy;
  logic        div_req;
  logic        div_sgn;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic [31:0] div_s;
  logic [31:0] div_r;
  logic        div_done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  int low_run = 0;
  int last_gap = 0;
  int div_cnt = 0;

  div_ctrl dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_flush(ex_flush), .stall(stall), .busy(busy), .div_req(div_req),
    .div_sgn(div_sgn), .div_x(div_x), .div_y(div_y), .div_s(div_s), .div_r(div_r),
    .div_done(div_done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider stand-in: counts while div_req is high, completes at count DIV_LATENCY,
  // and works on magnitudes with sign correction from its live inputs
  always @(posedge clk) div_cnt <= div_req ? div_cnt + 1 : 0;
  assign div_done = div_req && (div_cnt == DIV_LATENCY);

  always_comb begin
    logic [31:0] ax, ay, uq, ur;
    ax = (div_sgn && div_x[31]) ? (32'd0 - div_x) : div_x;
    ay = (div_sgn && div_y[31]) ? (32'd0 - div_y) : div_y;
    if (ay == 32'd0) begin
      uq = 32'hFFFF_FFFF;
      ur = ax;
    end else begin
      uq = ax / ay;
      ur = ax % ay;
    end
    div_s = (div_sgn && (div_x[31] ^ div_y[31])) ? (32'd0 - uq) : uq;
    div_r = (div_sgn && div_x[31]) ? (32'd0 - ur) : ur;
  end

  // Length of the most recent run of div_req-low cycles between divides
  always @(negedge clk) begin
    if (!div_req) begin
      low_run <= low_run + 1;
    end else begin
      if (low_run != 0) last_gap <= low_run;
      low_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (sgn) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Issue one divide; flush_at/reset_at give the EX-occupancy cycle (0 = request cycle) to kill it
  task automatic do_div(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int flush_at, input int reset_at, input bit toggle_rs, input string tag);
    logic [31:0] q, r;
    int stalls, c, exp_stalls;
    bit done, aborted, skip;
    skip = 1'b0;
`ifdef DIV_ZERO_SKIP_EN
    skip = (rt == 32'd0);
`endif
    exp_stalls = skip ? 0 : DIV_LATENCY + 1;
    ref_div(op == OP_DIV, rs, rt, q, r);
    ex_valid = 1'b1; ex_op = op; ex_rs = rs; ex_rt = rt;
    stalls = 0; c = 0; done = 1'b0; aborted = 1'b0;
    while (!done && !aborted && c < 80) begin
      if (c == flush_at) ex_flush = 1'b1;
      if (c == reset_at) reset = 1'b1;
      if (toggle_rs && c > 0) ex_rs = $urandom;
      @(negedge clk);
      if (c == flush_at || c == reset_at) aborted = 1'b1;
      else if (stall) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
      ex_flush = 1'b0; reset = 1'b0; c++;
    end
    ex_valid = 1'b0; ex_op = OP_NONE;
    #1;
    check({tag, ".finished"}, 32'(done | aborted), 32'd1);
    if (c == reset_at + 1) begin
      exp_hi = '0; exp_lo = '0;
      check({tag, ".rst_stalls"}, stalls, reset_at);
      check({tag, ".rst_x"}, div_x, 32'd0);
      check({tag, ".rst_y"}, div_y, 32'd0);
      check({tag, ".rst_sgn"}, 32'(div_sgn), 32'd0);
    end else if (c == flush_at + 1) begin
      check({tag, ".flush_stalls"}, stalls, flush_at);
    end else begin
      check({tag, ".stalls"}, stalls, exp_stalls);
      if (!skip) begin
        exp_lo = q; exp_hi = r;
      end
    end
    check({tag, ".stall_after"}, 32'(stall), 32'd0);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check({tag, ".req_after"}, 32'(div_req), 32'd0);
    check({tag, ".lo"}, lo, exp_lo);
    check({tag, ".hi"}, hi, exp_hi);
  endtask

  // One-cycle MTHI/MTLO; value must be visible right after the edge
  task automatic do_mt(input logic [2:0] op, input logic [31:0] val, input string tag);
    ex_valid = 1'b1; ex_op = op; ex_rs = val;
    @(negedge clk);
    check({tag, ".stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    if (op == OP_MTHI) exp_hi = val; else exp_lo = val;
    ex_valid = 1'b0; ex_op = OP_NONE;
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
  endtask

  initial begin
    logic [31:0] rs, rt, mv;
    int k;
    reset = 1'b1; ex_valid = 1'b0; ex_op = OP_NONE; ex_rs = '0; ex_rt = '0; ex_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.req", 32'(div_req), 32'd0);
    check("reset.x", div_x, 32'd0);
    check("reset.y", div_y, 32'd0);
    check("reset.sgn", 32'(div_sgn), 32'd0);
    @(posedge clk); #1;

    do_div(OP_DIVU, 32'd7, 32'd2, -1, -1, 1'b0, "divu_7_2");
    check("divu_7_2.lo_const", lo, 32'd3);
    check("divu_7_2.hi_const", hi, 32'd1);

    do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b1, "div_m7_2");
    check("div_m7_2.lo_const", lo, 32'hFFFF_FFFD);
    check("div_m7_2.hi_const", hi, 32'hFFFF_FFFF);

    do_div(OP_DIVU, 32'd100, 32'd7, 11, -1, 1'b0, "flush_b10");
    check("flush_b10.lo_kept", lo, 32'hFFFF_FFFD);
    do_div(OP_DIVU, 32'd100, 32'd7, -1, -1, 1'b0, "divu_100_7");
    check("divu_100_7.lo_const", lo, 32'd14);
    check("divu_100_7.hi_const", hi, 32'd2);

    @(posedge clk); #1;
    do_div(OP_DIV, 32'd20, 32'd3, -1, -1, 1'b0, "b2b_first");
    do_div(OP_DIVU, 32'hFFFF_FFFF, 32'd16, -1, -1, 1'b0, "b2b_second");
    check("b2b.gap", last_gap, 32'd1);
    check("b2b.lo_const", lo, 32'h0FFF_FFFF);

    do_mt(OP_MTHI, 32'hA5A5_A5A5, "mthi");
    do_mt(OP_MTLO, 32'h5A5A_5A5A, "mtlo");
    do_div(OP_DIV, 32'd50, 32'hFFFF_FFFA, -1, -1, 1'b0, "div_after_mt");

    do_div(OP_DIVU, 32'd5, 32'd0, -1, -1, 1'b0, "divu_5_0");

    do_div(OP_DIVU, 32'd1000, 32'd3, -1, 21, 1'b0, "reset_b20");
    do_div(OP_DIVU, 32'd9, 32'd4, -1, -1, 1'b0, "divu_9_4");
    check("divu_9_4.lo_const", lo, 32'd2);

    for (int i = 0; i < 12; i++) begin
      k  = $urandom_range(0, 3);
      rs = $urandom;
      rt = $urandom;
      if ($urandom_range(0, 1) == 1) rt = $urandom_range(1, 300);
      if ($urandom_range(0, 1) == 1) rt = 32'd0 - rt;
      if (rt == 32'd0) rt = 32'd1;
      if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd2;
      mv = $urandom;
      case (k)
        0: do_div(OP_DIV, rs, rt, -1, -1, 1'b1, "rand_div");
        1: do_div(OP_DIVU, rs, rt, -1, -1, 1'b0, "rand_divu");
        2: do_mt(OP_MTHI, mv, "rand_mthi");
        default: do_mt(OP_MTLO, mv, "rand_mtlo");
      endcase
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing and HI/LO stage wrapped around the iterative 32-bit divider. It accepts DIV/DIVU/MTHI/MTLO from the EX stage and latches the divide operands. It drives the divider's request/operand inputs, stalls the pipeline until the quotient/remainder arrive, and commits them to the architectural HI/LO registers. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- No parameters; widths fixed at 32.
- `clk` in 1: core clock, shared with the divider.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_op` in 3: `OP_NONE`, `OP_DIV`, `OP_DIVU`, `OP_MTHI`, `OP_MTLO`.
- `ex_rs` in 32: dividend, or MTHI/MTLO source.
- `ex_rt` in 32: divisor.
- `ex_flush` in 1: exception/flush; kills the current request.
- `stall` out 1: holds IF–EX.
- `busy` out 1: a divide is in flight.
- `div_req` out 1: the divider's `div` input.
- `div_sgn` out 1: the divider's `div_signed` input.
- `div_x` out 32: divider dividend.
- `div_y` out 32: divider divisor.
- `div_s` in 32: divider quotient.
- `div_r` in 32: divider remainder.
- `div_done` in 1: divider `complete`.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - `div_req` = 0.
  - On `ex_valid & ~ex_flush`:
    - `OP_DIV`/`OP_DIVU`: latch `ex_rs`→`div_x`, `ex_rt`→`div_y`, sign (1 for DIV)→`div_sgn`; `stall` = 1 this cycle; go to BUSY.
    - `OP_MTHI`/`OP_MTLO`: write `ex_rs` to `hi`/`lo` at the clock edge; no stall.
    - Otherwise: no action.
- BUSY:
  - `div_req` = 1; `busy` = 1.
  - `div_x`, `div_y`, `div_sgn` are held constant, because the divider sign-corrects from its live inputs.
  - `stall` = ~`div_done`.
  - On `div_done`: `lo` ← `div_s`, `hi` ← `div_r`; go to IDLE.
  - EX inputs are ignored, apart from `ex_flush`.
- Flush in BUSY: go to IDLE immediately; no HI/LO write; `div_req` drops next cycle.
- Flush outranks `div_done` in the same cycle, so HI/LO stay unchanged.
- `div_req` is always low for at least one cycle between divides. The divider clears its iteration count only while `div_req` is low. Back-to-back divides therefore always pass through IDLE.
- Reset (any state, including mid-divide):
  - State → IDLE.
  - `hi`, `lo`, `div_x`, `div_y` = 0; `div_sgn`, `div_req`, `stall`, `busy` = 0.
  - The first post-reset cycle holds `div_req` low, which clears the divider counter.
- Signed results follow the divider's convention:
  - Quotient sign = xor of operand signs.
  - Remainder sign = dividend sign.
  - No overflow trap: 0x80000000 / −1 commits whatever the divider produces.

## Timing
- Request cycle T (IDLE): `stall` = 1.
- BUSY cycles B0…B33: `div_req` = 1; divider count is 0 at B0; `div_done` = 1 at B33.
- `stall` is 1 for T and B0–B32, and 0 in B33.
- HI/LO update at the end of B33; the instruction leaves EX at the same edge.
- Total EX occupancy: 35 cycles.
- MTHI/MTLO: 1 cycle; the new value is visible on `hi`/`lo` in the next cycle.
- `hi`/`lo` are registered; no bypass.

## Configuration
- `DIV_ZERO_SKIP_EN` defined:
  - DIV/DIVU with `ex_rt` == 0 does not enter BUSY and asserts no stall.
  - HI/LO are left unchanged; 1-cycle instruction.
- `DIV_ZERO_SKIP_EN` undefined: divide-by-zero runs the full 35-cycle sequence and commits the divider output.

## Structure
- Shared package holds:
  - `ex_op` encoding (`OP_*`).
  - State enum (`DC_IDLE`, `DC_BUSY`).
  - Constant `DIV_LATENCY` = 33.
- Sub-module `hilo_regs`: the two 32-bit registers with write enables and synchronous reset.
- FSM and operand latches live in `div_ctrl`. The divider is instantiated by the parent, not here.

## Test plan
- DIVU 7/2 → stall 34 cycles; then `lo` = 3, `hi` = 1; `div_req` low the following cycle.
- DIV −7/2 (0xFFFFFFF9, 2) → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF; `ex_rs` toggled during BUSY has no effect.
- DIVU 100/7, flush at B10 → HI/LO unchanged, `stall` = 0 next cycle. A following DIVU 100/7 yields `lo` = 14, `hi` = 2 after the full 35 cycles.
- Back-to-back:
  - DIV 20/3 then DIVU 0xFFFFFFFF/16 → `lo`/`hi` = 6/2, then 0x0FFFFFFF/15.
  - Exactly one `div_req`-low cycle between the two divides.
- MTHI 0xA5A5A5A5, MTLO 0x5A5A5A5A in consecutive cycles → no stall; values visible one cycle later. A subsequent DIV overwrites both.
- Divide-by-zero:
  - DIVU 5/0 with `DIV_ZERO_SKIP_EN` → no stall; HI/LO retain prior values.
  - Without the macro → 34 stall cycles.
  - `reset` asserted at B20 → all outputs 0 next cycle; the next DIVU 9/4 gives `lo` = 2, `hi` = 1.
